// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared defaults and types for the datapath register file.
//   RF_WIDTH_DEFAULT : default bits per register word
//   RF_DEPTH_DEFAULT : default number of registers
//   rf_word_t        : one default-width register word
package regfile_pkg;

  localparam int RF_WIDTH_DEFAULT = 16;
  localparam int RF_DEPTH_DEFAULT = 8;

  typedef logic [RF_WIDTH_DEFAULT-1:0] rf_word_t;

endpackage : regfile_pkg

// File: rtl/register_file_reg_cell.sv
// reg_cell
//   One storage word of the register file with synchronous active-high
//   reset and a load enable.
//   clk   : clock, state updates on rising edge
//   reset : synchronous active-high clear
//   load  : when high, the word captures din on the next edge
//   din   : data to store
//   dout  : stored word
module reg_cell import regfile_pkg::*; #(
  parameter int WIDTH = RF_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] word_q;

  // Next-state selection: hold unless loaded.
  always_comb begin
    word_d = word_q;
    if (load) begin
      word_d = din;
    end else begin
      word_d = word_q;
    end
  end

  // Storage flop with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= {WIDTH{1'b0}};
    end else begin
      word_q <= word_d;
    end
  end

  assign dout = word_q;

endmodule : reg_cell

// File: rtl/register_file.sv
// register_file
//   DEPTH x WIDTH register file with one synchronous write port and two
//   registered read ports, optional hardwired zero register and optional
//   write-to-read bypass.
//   clk              : clock, all state updates on rising edge
//   reset            : synchronous active-high; clears words and outputs
//   we/waddr/wdata   : write port
//   raddr_a/raddr_b  : read addresses, sampled every edge
//   rdata_a/rdata_b  : registered read data (1-cycle latency)
module register_file import regfile_pkg::*; #(
  parameter int WIDTH    = RF_WIDTH_DEFAULT,
  parameter int DEPTH    = RF_DEPTH_DEFAULT,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b
);

  // One extra bit so DEPTH itself is representable for range checks.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] cell_q [DEPTH];
  logic             wr_en_s;
  logic [WIDTH-1:0] stored_a_s;
  logic [WIDTH-1:0] stored_b_s;
  logic [WIDTH-1:0] rdata_a_d;
  logic [WIDTH-1:0] rdata_a_q;
  logic [WIDTH-1:0] rdata_b_d;
  logic [WIDTH-1:0] rdata_b_q;

  // Address lies inside the implemented words (matters for non-power-of-two DEPTH).
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_L);
  endfunction

  // Address names the hardwired zero register.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return ZERO_REG && (addr == {ADDR_W{1'b0}});
  endfunction

  // Read-port selection shared by both ports. Priority: zero register,
  // out-of-range, bypass of an effective write, then stored contents.
  function automatic logic [WIDTH-1:0] read_sel(
    input logic [ADDR_W-1:0] raddr,
    input logic [WIDTH-1:0]  stored,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [WIDTH-1:0]  wr_data
  );
    logic [WIDTH-1:0] res;
    if (is_zero_reg(raddr)) begin
      res = {WIDTH{1'b0}};
    end else if (!in_range(raddr)) begin
      res = {WIDTH{1'b0}};
    end else if (BYPASS && wr_en && (raddr == wr_addr)) begin
      res = wr_data;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  // A write only takes effect to an implemented, writable word.
  assign wr_en_s = we && in_range(waddr) && !is_zero_reg(waddr);

  // Storage words; word 0 is a constant when the zero register is enabled.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    if (ZERO_REG && (i == 0)) begin : g_zero
      assign cell_q[i] = {WIDTH{1'b0}};
    end else begin : g_word
      reg_cell #(.WIDTH(WIDTH)) u_cell (
        .clk   (clk),
        .reset (reset),
        .load  (wr_en_s && (waddr == ADDR_W'(i))),
        .din   (wdata),
        .dout  (cell_q[i])
      );
    end
  end

  // Pre-edge word lookup for both read ports; unmatched addresses yield zero.
  always_comb begin
    stored_a_s = {WIDTH{1'b0}};
    stored_b_s = {WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == ADDR_W'(i)) begin
        stored_a_s = cell_q[i];
      end else begin
        stored_a_s = stored_a_s;
      end
      if (raddr_b == ADDR_W'(i)) begin
        stored_b_s = cell_q[i];
      end else begin
        stored_b_s = stored_b_s;
      end
    end
  end

  // Next read data for each port.
  always_comb begin
    rdata_a_d = read_sel(raddr_a, stored_a_s, wr_en_s, waddr, wdata);
    rdata_b_d = read_sel(raddr_b, stored_b_s, wr_en_s, waddr, wdata);
  end

  // Registered read outputs with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a_q <= {WIDTH{1'b0}};
      rdata_b_q <= {WIDTH{1'b0}};
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule : register_file

// File: doc/register_file.md
# register_file

Parametrised multi-port register file for the 16-bit processor datapath, generalising the single 16-bit storage register to DEPTH words of WIDTH bits. It has one synchronous write port and two registered read ports. It sits between the decode stage, which supplies the addresses, and the ALU operand muxes, which consume rdata_a/rdata_b. Optional features are a hardwired zero register and write-to-read bypass.

## Interface
- WIDTH, 16, bits per register word
- DEPTH, 8, number of registers; any value ≥ 2
- ZERO_REG, 1, if 1 register 0 always reads 0 and ignores writes
- BYPASS, 1, if 1 a same-cycle write to a read address is forwarded to that read port
- ADDR_W, derived localparam = $clog2(DEPTH), not overridable
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all registers and both read outputs
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- raddr_a  input  ADDR_W  read port A address
- raddr_b  input  ADDR_W  read port B address
- rdata_a  output  WIDTH  registered read data, port A
- rdata_b  output  WIDTH  registered read data, port B

## Operation
- Reset: on any rising edge with reset=1, all DEPTH words become 0 and rdata_a/rdata_b become 0. Reset overrides a simultaneous write.
- Write: on a rising edge with reset=0 and we=1, mem[waddr] ← wdata. The write is ignored if waddr ≥ DEPTH (non-power-of-two DEPTH) or if ZERO_REG=1 and waddr=0.
- Read: each port independently, on every rising edge with reset=0:
  - If ZERO_REG=1 and raddr=0: rdata ← 0.
  - Else if raddr ≥ DEPTH: rdata ← 0.
  - Else if BYPASS=1, we=1 and raddr=waddr (write not suppressed): rdata ← wdata.
  - Else: rdata ← mem[raddr], the pre-edge value.
- Both ports may read the same address. Both may hit the bypass in the same cycle.
- No arithmetic. Data passes through unmodified at full WIDTH, with no truncation or extension.

## Timing
- Write latency: 1 cycle. Data written at edge N is visible through a non-bypassed read issued at edge N+1, with rdata valid after edge N+1.
- Read latency: 1 cycle. The address presented before edge N produces rdata valid after edge N, held until the next edge.
- Bypass, BYPASS=1: a read and a write to the same address in the same cycle return the new wdata after that edge.
- No bypass, BYPASS=0: the same case returns the old contents. The new value appears on the next read.
- Reset mid-operation: pending writes in that cycle are dropped. Outputs read 0 the cycle after reset is sampled high. Normal operation resumes on the first edge with reset=0.
- Every output's reset value is 0.

## Structure
- Package regfile_pkg holds:
  - RF_WIDTH_DEFAULT = 16
  - RF_DEPTH_DEFAULT = 8
  - rf_word_t = logic [RF_WIDTH_DEFAULT-1:0]
- Sub-module reg_cell: one WIDTH-bit word with sync active-high reset and load enable. It is instantiated DEPTH times through a generate loop, and cell 0 is omitted when ZERO_REG=1.
- Read-port logic is a shared function or block replicated for ports A and B.

## Test plan
- Reset then read all: assert reset 1 cycle, read every address on both ports → rdata_a = rdata_b = 16'h0000 for all.
- Write/read back: write 16'h0003 to r1, 16'h000D to r7, then read r1 on A and r7 on B next cycle → rdata_a=16'h0003, rdata_b=16'h000D one cycle after the read.
- Zero register (ZERO_REG=1): write 16'hFFFF to r0, read r0 → 16'h0000. With ZERO_REG=0 the same sequence → 16'hFFFF.
- Bypass: r2 holds 16'h1111; in one cycle write 16'h2222 to r2 while both ports read r2 → 16'h2222 after that edge with BYPASS=1, 16'h1111 with BYPASS=0, and 16'h2222 on the following read in both cases.
- Reset with write: reset=1 and we=1 writing 16'h00AB to r3 in the same cycle → next read of r3 returns 16'h0000 and both rdata are 0 after the reset edge.
- Out-of-range (DEPTH=6): write 16'h5555 to address 7, read address 7 → 16'h0000, and no other register changes.
